// File: rtl/oam_dma_bus.sv
// OAM DMA bus front-end: CPU pass-through, 127-byte HRAM, FF46 DMA register and OAM copy engine.
// Optional build macro OAM_DMA_ECHO_FOLD_EN folds sources E0..FF down onto C0..DF.
module oam_dma_bus #(
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          LENGTH       = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic [7:0]  cpu_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, START, RD, WR} state_t;

  localparam logic [8:0] LEN = 9'(LENGTH);

  state_t     state, state_next;
  logic [7:0] idx, dma_reg, latch, src;
  logic       restart;  // START entered while the fence was already up
  logic       hram_hit, reg_hit, reg_wr, last_byte;
  logic [7:0] hram [0:127];

  assign hram_hit  = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
  assign reg_hit   = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr    = cpu_write && reg_hit;
  assign last_byte = ({1'b0, idx} + 9'd1) >= LEN;

`ifdef OAM_DMA_ECHO_FOLD_EN
  assign src = (dma_reg >= 8'hE0) ? dma_reg - 8'h20 : dma_reg;
`else
  assign src = dma_reg;
`endif

  // NOTE: sequential state uses non-blocking assignments; rst is async so the bus is released at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = IDLE;
      START:   state_next = RD;
      RD:      state_next = WR;
      WR:      state_next = last_byte ? IDLE : RD;
      default: state_next = IDLE;
    endcase
    if (reg_wr) state_next = START;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 8'd0;
      dma_reg <= 8'hFF;
      latch   <= 8'd0;
      restart <= 1'b0;
    end else begin
      if (state == RD) latch <= bus_d_in;
      if (reg_wr) begin
        dma_reg <= cpu_d_out;
        idx     <= 8'd0;
        restart <= dma_active;
      end else if (state == WR) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // NOTE: HRAM is deliberately not reset; it maps to a plain RAM array.
  always_ff @(posedge clk) begin
    if (cpu_write && hram_hit) hram[cpu_addr[6:0]] <= cpu_d_out;
  end

  assign dma_active = (state == RD) || (state == WR) || ((state == START) && restart);

  always_comb begin
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = cpu_write && !hram_hit && !reg_hit;
    if (dma_active) begin
      bus_addr  = {src, idx};
      bus_d_out = latch;
      bus_write = 1'b0;
      if (state == WR) begin
        bus_addr  = OAM_BASE + {8'h00, idx};
        bus_write = 1'b1;
      end
    end
  end

  always_comb begin
    cpu_d_in = bus_d_in;
    if (hram_hit)        cpu_d_in = hram[cpu_addr[6:0]];
    else if (reg_hit)    cpu_d_in = dma_reg;
    else if (dma_active) cpu_d_in = 8'hFF;
  end

endmodule

// File: tb/tb_oam_dma_bus.sv
// Directed bench for oam_dma_bus: idle pass-through table, full transfer, restarts, reset and echo source.
module tb_oam_dma_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  cpu_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  int checks = 0;
  int errors = 0;

  oam_dma_bus dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_write(cpu_write), .cpu_d_in(cpu_d_in),
    .bus_addr(bus_addr), .bus_d_out(bus_d_out), .bus_write(bus_write), .bus_d_in(bus_d_in),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // System bus memory model: contents are a fixed function of the address.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction
  assign bus_d_in = mem(bus_addr);

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic        exp_bw;
    logic        chk_din;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cpu(input logic [15:0] a, input logic [7:0] d, input logic w);
    cpu_addr = a; cpu_d_out = d; cpu_write = w;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One DMA byte: RD clock then WR clock, CPU idle during WR.
  task automatic byte_pair(input logic [7:0] s, input int i);
    #1;
    check("rd_addr", bus_addr, {s, 8'(i)});
    check("rd_write", {15'd0, bus_write}, 16'd0);
    check("rd_active", {15'd0, dma_active}, 16'd1);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    #1;
    check("wr_addr", bus_addr, 16'hFE00 + 16'(i));
    check("wr_write", {15'd0, bus_write}, 16'd1);
    check("wr_data", {8'd0, bus_d_out}, {8'd0, mem({s, 8'(i)})});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'hC000, 8'h00, 1'b0, 1'b0, 1'b1, mem(16'hC000)};
    vecs[1] = '{16'hC000, 8'hAB, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{16'hFF80, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{16'hFF80, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{16'hFFFE, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{16'hFFFE, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[6] = '{16'hFFFF, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{16'hFFFF, 8'h00, 1'b0, 1'b0, 1'b1, mem(16'hFFFF)};
    vecs[8] = '{16'hFF46, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[9] = '{16'hFF7F, 8'h00, 1'b0, 1'b0, 1'b1, mem(16'hFF7F)};

    rst = 1'b1;
    set_cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("reset_active", {15'd0, dma_active}, 16'd0);
    check("reset_ff46", {8'd0, cpu_d_in}, 16'h00FF);
    tick();
    rst = 1'b0;

    // Idle pass-through and HRAM decode.
    for (int v = 0; v < 10; v++) begin
      set_cpu(vecs[v].addr, vecs[v].dout, vecs[v].wr);
      #1;
      check("vec_bus_addr", bus_addr, vecs[v].addr);
      check("vec_bus_write", {15'd0, bus_write}, {15'd0, vecs[v].exp_bw});
      if (vecs[v].wr) check("vec_bus_dout", {8'd0, bus_d_out}, {8'd0, vecs[v].dout});
      if (vecs[v].chk_din) check("vec_d_in", {8'd0, cpu_d_in}, {8'd0, vecs[v].exp_din});
      check("vec_idle", {15'd0, dma_active}, 16'd0);
      tick();
    end

    // Full transfer from C100 with CPU traffic in flight.
    set_cpu(16'hFF46, 8'hC1, 1'b1);
    #1;
    check("trig_bus_write", {15'd0, bus_write}, 16'd0);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    #1;
    check("fresh_start_fence", {15'd0, dma_active}, 16'd0);
    tick();
    for (int i = 0; i < 160; i++) begin
      if (i == 10) set_cpu(16'hFF90, 8'h5A, 1'b1);
      if (i == 20) begin
        set_cpu(16'h8000, 8'h00, 1'b0);
        #1;
        check("fenced_read", {8'd0, cpu_d_in}, 16'h00FF);
      end
      if (i == 30) set_cpu(16'h8000, 8'h77, 1'b1);
      if (i == 40) begin
        set_cpu(16'hFF90, 8'h00, 1'b0);
        #1;
        check("hram_during_dma", {8'd0, cpu_d_in}, 16'h005A);
      end
      byte_pair(8'hC1, i);
    end
    #1;
    check("done_after_321", {15'd0, dma_active}, 16'd0);
    set_cpu(16'hFF90, 8'h00, 1'b0);
    #1;
    check("hram_after_dma", {8'd0, cpu_d_in}, 16'h005A);

    // Restart at idx 50 with a new source.
    set_cpu(16'hFF46, 8'hC1, 1'b1);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 50; i++) byte_pair(8'hC1, i);
    set_cpu(16'hFF46, 8'hD0, 1'b1);
    #1;
    check("restart_rd_addr", bus_addr, 16'hC132);
    check("restart_rd_active", {15'd0, dma_active}, 16'd1);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    #1;
    check("restart_start_fence", {15'd0, dma_active}, 16'd1);
    tick();
    for (int i = 0; i < 159; i++) byte_pair(8'hD0, i);

    // Restart written in the final WR clock.
    #1;
    check("last_rd_addr", bus_addr, 16'hD09F);
    tick();
    set_cpu(16'hFF46, 8'hC3, 1'b1);
    #1;
    check("last_wr_addr", bus_addr, 16'hFE9F);
    check("last_wr_write", {15'd0, bus_write}, 16'd1);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    #1;
    check("last_wr_restart_fence", {15'd0, dma_active}, 16'd1);
    tick();
    byte_pair(8'hC3, 0);

    // Asynchronous reset in the middle of RD.
    #1;
    check("pre_reset_rd", bus_addr, 16'hC301);
    rst = 1'b1;
    set_cpu(16'h1234, 8'h99, 1'b1);
    #1;
    check("rst_active", {15'd0, dma_active}, 16'd0);
    check("rst_bus_addr", bus_addr, 16'h1234);
    check("rst_bus_write", {15'd0, bus_write}, 16'd1);
    set_cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("rst_ff46", {8'd0, cpu_d_in}, 16'h00FF);
    rst = 1'b0;
    tick();

    // Echo-range source.
    set_cpu(16'hFF46, 8'hE2, 1'b1);
    tick();
    set_cpu(16'h0000, 8'h00, 1'b0);
    tick();
    #1;
`ifdef OAM_DMA_ECHO_FOLD_EN
    check("echo_rd_addr", bus_addr, 16'hC200);
`else
    check("echo_rd_addr", bus_addr, 16'hE200);
`endif
    set_cpu(16'hFF46, 8'h00, 1'b0);
    #1;
    check("echo_readback", {8'd0, cpu_d_in}, 16'h00E2);
    rst = 1'b1;
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_bus.md
Name: oam_dma_bus

Overview:
- Sits directly downstream of the sm83 core's memory port (addr, d_out, write, d_in) and in front of the system bus.
- Passes CPU cycles through to the bus.
- Hosts the 127-byte HRAM (FF80–FFFE) and the DMA source register (FF46).
- Runs OAM DMA: copies LENGTH bytes from {src,8'h00} to OAM_BASE. While a transfer runs, the CPU is fenced off the bus and sees only HRAM and FF46.

Parameters:
OAM_BASE, 16'hFE00, OAM destination base address
DMA_REG_ADDR, 16'hFF46, address of the DMA source/trigger register
LENGTH, 160, bytes per transfer (1..256)

Ports:
clk  in  1  system clock; one tick per core step
rst  in  1  reset, asynchronous, active-high
cpu_addr  in  16  core address
cpu_d_out  in  8  core write data
cpu_write  in  1  core write strobe, sampled at posedge clk
cpu_d_in  out  8  read data returned to core (combinational)
bus_addr  out  16  system bus address
bus_d_out  out  8  system bus write data
bus_write  out  1  system bus write strobe
bus_d_in  in  8  system bus read data
dma_active  out  1  high while the CPU is fenced off the bus

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, idx = 0, dma_reg = 8'hFF, latch = 0, dma_active = 0.
  - HRAM contents are not reset.
- Decode:
  - hram_hit = cpu_addr in FF80..FFFE.
  - reg_hit = (cpu_addr == DMA_REG_ADDR).
- States and transitions:
  - IDLE → START on a clocked write with reg_hit.
  - START lasts exactly 1 clock, then goes to RD.
  - RD → WR after one clock.
  - WR → RD while idx+1 < LENGTH; otherwise WR → IDLE.
- Register writes: any write with reg_hit, in any state, stores dma_reg <= cpu_d_out and idx <= 0, and enters START.
- RD: bus_addr = {src,idx}, bus_write = 0. On the clock edge, latch <= bus_d_in.
- WR: bus_addr = OAM_BASE + idx, bus_d_out = latch, bus_write = 1. On the clock edge, idx <= idx + 1.
- Transfer timing: 2 clocks per byte plus the 1-clock START. A full transfer is 1 + 2*LENGTH clocks (321 at default).
- dma_active:
  - High in RD and WR.
  - In START it is high only if the transfer was a restart, i.e. the previous state was RD or WR. A fresh start therefore fences 1 clock late; a restart never drops the fence.
- Not active:
  - bus_addr = cpu_addr, bus_d_out = cpu_d_out.
  - bus_write = cpu_write && !hram_hit && !reg_hit.
- Active:
  - The DMA drives the bus.
  - CPU non-HRAM, non-reg reads return 8'hFF; CPU non-HRAM, non-reg writes are dropped.
- cpu_d_in, in priority order:
  1. hram_hit: hram[cpu_addr[6:0]]
  2. reg_hit: dma_reg
  3. dma_active: 8'hFF
  4. otherwise: bus_d_in
- HRAM:
  - Asynchronous read.
  - Write on the clock edge when cpu_write && hram_hit, in every state.
  - HRAM traffic is never forwarded to the bus.
- FFFF is not HRAM; it passes to the bus like any other address.
- A write to FF46 in the final WR clock restarts the transfer; the state does not pass through IDLE.
- Reset mid-transfer: the bus is released immediately and asynchronously, with dma_active = 0 and bus_write following the CPU.
- src = dma_reg, or the folded value (see Optional Feature). src is resolved at each RD, so a restart uses the new value.

Optional Feature:
- Macro: OAM_DMA_ECHO_FOLD_EN.
- Defined: when dma_reg >= 8'hE0, src = dma_reg - 8'h20, so source E000–FFFF reads C000–DFFF (echo RAM). dma_reg readback is still the raw value written.
- Undefined: src = dma_reg verbatim, for all values.

Test Plan:
- Reset, then CPU reads FF46 → 8'hFF. CPU write to C000 → bus_write=1, bus_addr=C000 the same cycle.
- Write FF46=8'hC1 → dma_active rises 1 clock later.
  - 160 bus writes FE00..FE9F carry the data read from C100..C19F.
  - dma_active falls after 321 clocks.
- During the transfer:
  - CPU write FF90=8'h5A → later read FF90=8'h5A, with no bus_write from the CPU.
  - CPU read 8000 → 8'hFF.
  - CPU write 8000 → dropped.
- At idx=50, write FF46=8'hD0 → dma_active stays high; the next RD address is D000; 160 bytes total from D000.
- Assert rst mid-RD → dma_active=0 and bus_addr=cpu_addr in the same cycle. FF46 reads back 8'hFF.
- Write FF46=8'hE2:
  - With OAM_DMA_ECHO_FOLD_EN: first RD address is C200.
  - Without OAM_DMA_ECHO_FOLD_EN: first RD address is E200.
  - Readback is 8'hE2 in both builds.
